// File: rtl/piezo_multi.sv
// Piezo slot-card controller. It handles SPI-configured DAC/ADC chip-select fan-out,
// debounced trigger capture with a sticky irq and an event counter, a latched emergency stop, and the one-wire ID pass-through.
module piezo_multi #(
    parameter int unsigned DEV_ID             = 0,
    parameter int unsigned UART_ADDRESS_WIDTH = 4,
    parameter int unsigned OW_ADDR_OFFSET     = 7,
    parameter int unsigned NUM_DAC_CH         = 2,
    parameter int unsigned NUM_ADC_CH         = 2,
    parameter int unsigned DEBOUNCE_CYCLES    = 16,
    parameter logic [15:0] CMD_ENABLE         = 16'h0000,
    parameter logic [15:0] CMD_TRIG_CFG       = 16'h0001,
    parameter logic [15:0] CMD_TRIG_CLR       = 16'h0002,
    parameter logic [15:0] CMD_CS_SEL         = 16'h0003
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [NUM_DAC_CH-1:0]         CS_DAC,
    output logic [NUM_ADC_CH-1:0]         CS_ADC,
    input  logic                          TRIGGER,
    inout  logic                          OW_ID,
    input  logic [15:0]                   spi_cmd_r,
    input  logic [7:0]                    spi_addr_r,
    input  logic [39:0]                   spi_data_r,
    input  logic                          spi_data_valid_r,
    input  logic                          cs_decoded_in,
    input  logic                          cs_decoded_in2,
    input  logic [UART_ADDRESS_WIDTH-1:0] uart_slot_en,
    output logic                          rx_slot,
    input  logic                          tx_slot,
    input  logic                          EM_STOP,
    output logic                          trig_irq,
    output logic [15:0]                   trig_count,
    output logic                          estop_latched
);

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned     OW_ADDR = DEV_ID + OW_ADDR_OFFSET;

    logic [2:0]      mode_q, mode_d;
    edge_mode_t      edge_mode_q, edge_mode_d;
    logic [2:0]      dac_sel_q, dac_sel_d;
    logic [2:0]      adc_sel_q, adc_sel_d;
    logic            irq_q, irq_d;
    logic [15:0]     count_q, count_d;
    logic            estop_q, estop_d;
    logic            em_meta_q, em_sync_q;
    logic            trig_meta_q, trig_sync_q;
    logic            filt_q, filt_d;
    logic            filt_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    logic slot_hit, wr_enable, wr_trig_cfg, wr_trig_clr, wr_cs_sel;
    logic dac_sel_ok, adc_sel_ok;
    logic clr_irq, clr_count;
    logic enabled, rise, fall, edge_hit, trig_event;
    logic ow_active;
    logic [NUM_DAC_CH-1:0] cs_dac_drv;
    logic [NUM_ADC_CH-1:0] cs_adc_drv;
    logic unused_data;

    assign slot_hit    = spi_data_valid_r && (32'(spi_addr_r) == DEV_ID);
    assign wr_enable   = slot_hit && (spi_cmd_r == CMD_ENABLE);
    assign wr_trig_cfg = slot_hit && (spi_cmd_r == CMD_TRIG_CFG);
    assign wr_trig_clr = slot_hit && (spi_cmd_r == CMD_TRIG_CLR);
    assign wr_cs_sel   = slot_hit && (spi_cmd_r == CMD_CS_SEL);
    assign dac_sel_ok  = 32'(spi_data_r[2:0]) < NUM_DAC_CH;
    assign adc_sel_ok  = 32'(spi_data_r[10:8]) < NUM_ADC_CH;
    assign clr_irq     = wr_trig_clr && spi_data_r[0];
    assign clr_count   = wr_trig_clr && spi_data_r[1];
    assign unused_data = ^{spi_data_r[39:11], spi_data_r[7:3]};

    always_comb begin
        mode_d      = mode_q;
        edge_mode_d = edge_mode_q;
        dac_sel_d   = dac_sel_q;
        adc_sel_d   = adc_sel_q;
        if (wr_enable)
            mode_d = spi_data_r[2:0];
        if (wr_trig_cfg)
            edge_mode_d = edge_mode_t'(spi_data_r[1:0]);
        // Out-of-range channel fields are dropped one at a time, so a single write can update one field and ignore the other.
        if (wr_cs_sel && dac_sel_ok)
            dac_sel_d = spi_data_r[2:0];
        if (wr_cs_sel && adc_sel_ok)
            adc_sel_d = spi_data_r[10:8];
    end

    always_comb begin
        estop_d = estop_q;
        if (em_sync_q)
            estop_d = 1'b1;
        else if (wr_enable && (spi_data_r[2:0] != '0))
            estop_d = 1'b0;
    end

    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (trig_sync_q != filt_q) begin
            if (db_cnt_q == DB_LAST)
                filt_d = trig_sync_q;
            else
                db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign enabled = (mode_q != '0) && !estop_q;
    assign rise    = filt_q && !filt_prev_q;
    assign fall    = !filt_q && filt_prev_q;

    always_comb begin
        case (edge_mode_q)
            EDGE_RISE: edge_hit = rise;
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise || fall;
            default:   edge_hit = 1'b0;
        endcase
    end

    assign trig_event = edge_hit && enabled;

    // If an event and a count clear land on the same cycle, the event wins. The clear then restarts the count at one.
    always_comb begin
        irq_d   = irq_q;
        count_d = count_q;
        if (clr_irq)
            irq_d = 1'b0;
        if (clr_count)
            count_d = '0;
        if (trig_event) begin
            irq_d = 1'b1;
            if (clr_count)
                count_d = 16'd1;
            else if (count_q != '1)
                count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= '0;
            edge_mode_q <= EDGE_OFF;
            dac_sel_q   <= '0;
            adc_sel_q   <= '0;
            irq_q       <= 1'b0;
            count_q     <= '0;
            estop_q     <= 1'b0;
            em_meta_q   <= 1'b0;
            em_sync_q   <= 1'b0;
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            mode_q      <= mode_d;
            edge_mode_q <= edge_mode_d;
            dac_sel_q   <= dac_sel_d;
            adc_sel_q   <= adc_sel_d;
            irq_q       <= irq_d;
            count_q     <= count_d;
            estop_q     <= estop_d;
            em_meta_q   <= EM_STOP;
            em_sync_q   <= em_meta_q;
            trig_meta_q <= TRIGGER;
            trig_sync_q <= trig_meta_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // The selected line carries the shared decode, and every other line of the group is held high.
    assign cs_dac_drv = enabled ? ~(NUM_DAC_CH'(!cs_decoded_in) << dac_sel_q) : '1;
    assign cs_adc_drv = enabled ? ~(NUM_ADC_CH'(!cs_decoded_in2) << adc_sel_q) : '1;

    assign CS_DAC = (mode_q == '0) ? 'z : cs_dac_drv;
    assign CS_ADC = (mode_q == '0) ? 'z : cs_adc_drv;

    assign ow_active = (mode_q != '0) && (32'(uart_slot_en) == OW_ADDR);
    assign OW_ID     = (ow_active && !tx_slot) ? 1'b0 : 1'bz;
    assign rx_slot   = ow_active ? OW_ID : 1'bz;

    assign trig_irq      = irq_q;
    assign trig_count    = count_q;
    assign estop_latched = estop_q;

endmodule

// File: tb/tb_piezo_multi.sv
// Scoreboard bench for piezo_multi. Expected values are queued as stimulus is driven and compared as outputs are sampled.
// Pulls on the tristate nets make high-Z observable: chip selects and rx_slot are pulled low, and OW_ID is pulled high.
module tb_piezo_multi;

    localparam logic [15:0] CMD_EN  = 16'h0000;
    localparam logic [15:0] CMD_CFG = 16'h0001;
    localparam logic [15:0] CMD_CLR = 16'h0002;
    localparam logic [15:0] CMD_SEL = 16'h0003;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig, trig2, em, em2, tx, cs_in, cs_in2, spi_valid;
    logic [15:0] spi_cmd;
    logic [7:0]  spi_addr;
    logic [39:0] spi_data;
    logic [3:0]  uart_en;

    tri0 [1:0]   cs_dac, cs_adc, cs_dac2, cs_adc2;
    tri1         ow_id, ow_id2;
    tri0         rx, rx2;
    logic        irq, irq2, estop, estop2;
    logic [15:0] count, count2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned lat;
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    always #5 clk = ~clk;

    piezo_multi dut (
        .clk(clk), .reset(rst), .CS_DAC(cs_dac), .CS_ADC(cs_adc), .TRIGGER(trig), .OW_ID(ow_id),
        .spi_cmd_r(spi_cmd), .spi_addr_r(spi_addr), .spi_data_r(spi_data), .spi_data_valid_r(spi_valid),
        .cs_decoded_in(cs_in), .cs_decoded_in2(cs_in2), .uart_slot_en(uart_en), .rx_slot(rx),
        .tx_slot(tx), .EM_STOP(em), .trig_irq(irq), .trig_count(count), .estop_latched(estop)
    );

    piezo_multi #(.DEV_ID(2), .DEBOUNCE_CYCLES(1)) dut_sat (
        .clk(clk), .reset(rst), .CS_DAC(cs_dac2), .CS_ADC(cs_adc2), .TRIGGER(trig2), .OW_ID(ow_id2),
        .spi_cmd_r(spi_cmd), .spi_addr_r(spi_addr), .spi_data_r(spi_data), .spi_data_valid_r(spi_valid),
        .cs_decoded_in(cs_in), .cs_decoded_in2(cs_in2), .uart_slot_en(uart_en), .rx_slot(rx2),
        .tx_slot(tx), .EM_STOP(em2), .trig_irq(irq2), .trig_count(count2), .estop_latched(estop2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        if (sb_exp.size() == 0) begin
            $display("FAIL sb_underflow: observed %0h with nothing queued", obs);
            $fatal(1, "scoreboard underflow");
        end
        tag = sb_tag.pop_front();
        exp = sb_exp.pop_front();
        check(tag, obs, exp);
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic spi_write(input logic [7:0] addr, input logic [15:0] cmd, input logic [39:0] data);
        spi_addr  = addr;
        spi_cmd   = cmd;
        spi_data  = data;
        spi_valid = 1'b1;
        @(posedge clk);
        #1;
        spi_valid = 1'b0;
        spi_data  = '0;
    endtask

    task automatic pulse(input int unsigned w);
        trig = 1'b1;
        cyc(w);
        trig = 1'b0;
    endtask

    task automatic chk_cs(input string tag, input logic [1:0] dac, input logic [1:0] adc);
        sb_push({tag, "_cs_dac"}, 32'(dac));
        sb_push({tag, "_cs_adc"}, 32'(adc));
        at_neg();
        sb_pop(32'(cs_dac));
        sb_pop(32'(cs_adc));
    endtask

    task automatic chk_trig(input string tag, input logic i, input logic [15:0] c);
        sb_push({tag, "_irq"}, 32'(i));
        sb_push({tag, "_count"}, 32'(c));
        at_neg();
        sb_pop(32'(irq));
        sb_pop(32'(count));
    endtask

    task automatic chk_ow(input string tag, input logic o, input logic r);
        sb_push({tag, "_ow_id"}, 32'(o));
        sb_push({tag, "_rx"}, 32'(r));
        at_neg();
        sb_pop(32'(ow_id));
        sb_pop(32'(rx));
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; trig2 = 1'b0; em = 1'b0; em2 = 1'b0; tx = 1'b1;
        uart_en = '0; cs_in = 1'b0; cs_in2 = 1'b0;
        spi_valid = 1'b0; spi_cmd = '0; spi_addr = '0; spi_data = '0;
        cyc(2);

        chk_trig("rst", 1'b0, 16'h0);
        chk_cs("rst", 2'b00, 2'b00);
        sb_push("rst_estop", 32'd0);
        sb_pop(32'(estop));
        rst = 1'b0;
        cyc(1);

        spi_write(8'd1, CMD_EN, 40'd1);
        chk_cs("wrong_addr", 2'b00, 2'b00);
        cs_in2 = 1'b1;
        spi_write(8'd0, CMD_EN, 40'd1);
        chk_cs("enable", 2'b10, 2'b11);
        cs_in = 1'b1; cs_in2 = 1'b0;
        chk_cs("route", 2'b11, 2'b10);
        cs_in = 1'b0;

        spi_write(8'd0, CMD_SEL, 40'h0101);
        chk_cs("sel1", 2'b01, 2'b01);
        spi_write(8'd0, CMD_SEL, 40'h0505);
        chk_cs("sel_oor", 2'b01, 2'b01);
        spi_write(8'd0, CMD_SEL, 40'h0500);
        chk_cs("sel_mixed", 2'b10, 2'b01);

        spi_write(8'd0, CMD_CFG, 40'd1);
        trig = 1'b1;
        lat = 0;
        for (int unsigned k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (irq && lat == 0)
                lat = k;
        end
        sb_push("rise_latency", 32'd19);
        sb_pop(32'(lat));
        cyc(5);
        chk_trig("rise", 1'b1, 16'd1);
        trig = 1'b0;
        cyc(30);
        chk_trig("fall_ignored", 1'b1, 16'd1);
        spi_write(8'd0, CMD_CLR, 40'd3);
        chk_trig("clr_both", 1'b0, 16'd0);

        pulse(10);
        cyc(30);
        chk_trig("glitch10", 1'b0, 16'd0);
        pulse(15);
        cyc(30);
        chk_trig("glitch15", 1'b0, 16'd0);
        pulse(16);
        cyc(40);
        chk_trig("pulse16", 1'b1, 16'd1);
        spi_write(8'd0, CMD_CLR, 40'd3);

        spi_write(8'd0, CMD_CFG, 40'd3);
        cyc(25);
        chk_trig("cfg_no_event", 1'b0, 16'd0);
        for (int unsigned p = 1; p <= 6; p++) begin
            trig = ~trig;
            sb_push("both_count", 32'(p));
            cyc(30);
            sb_pop(32'(count));
        end
        chk_trig("both_done", 1'b1, 16'd6);

        trig = 1'b1;
        cyc(18);
        spi_write(8'd0, CMD_CLR, 40'd3);
        chk_trig("coincident", 1'b1, 16'd1);
        trig = 1'b0;
        cyc(25);
        chk_trig("after_coinc", 1'b1, 16'd2);
        spi_write(8'd0, CMD_CLR, 40'd2);
        chk_trig("clr_count_only", 1'b1, 16'd0);
        spi_write(8'd0, CMD_CLR, 40'd1);
        chk_trig("clr_irq_only", 1'b0, 16'd0);

        chk_cs("pre_estop", 2'b10, 2'b01);
        em = 1'b1;
        cyc(4);
        sb_push("estop_set", 32'd1);
        sb_pop(32'(estop));
        chk_cs("estop", 2'b11, 2'b11);
        trig = 1'b1;
        cyc(30);
        chk_trig("estop_edges", 1'b0, 16'd0);
        spi_write(8'd0, CMD_EN, 40'd1);
        cyc(2);
        sb_push("estop_enable_while_high", 32'd1);
        sb_pop(32'(estop));
        em = 1'b0;
        cyc(4);
        sb_push("estop_after_release", 32'd1);
        sb_pop(32'(estop));
        chk_cs("estop_held", 2'b11, 2'b11);
        spi_write(8'd0, CMD_EN, 40'd1);
        sb_push("estop_cleared", 32'd0);
        sb_pop(32'(estop));
        chk_cs("estop_restored", 2'b10, 2'b01);

        uart_en = 4'd7; tx = 1'b0;
        chk_ow("ow_tx0", 1'b0, 1'b0);
        tx = 1'b1;
        chk_ow("ow_tx1", 1'b1, 1'b1);
        tx = 1'b0;
        chk_ow("ow_tx0b", 1'b0, 1'b0);
        uart_en = 4'd0;
        chk_ow("ow_other_addr", 1'b1, 1'b0);
        uart_en = 4'd7;
        spi_write(8'd0, CMD_EN, 40'd0);
        chk_ow("ow_mode0", 1'b1, 1'b0);
        chk_cs("mode0", 2'b00, 2'b00);

        spi_write(8'd0, CMD_EN, 40'd1);
        tx = 1'b1; uart_en = 4'd0;
        trig = 1'b0;
        cyc(25);
        chk_trig("pre_reset", 1'b1, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        sb_push("async_rst_irq", 32'd0);
        sb_push("async_rst_count", 32'd0);
        sb_push("async_rst_cs_dac", 32'd0);
        sb_pop(32'(irq));
        sb_pop(32'(count));
        sb_pop(32'(cs_dac));
        cyc(2);
        rst = 1'b0;
        cyc(2);

        spi_write(8'd2, CMD_EN, 40'd1);
        spi_write(8'd2, CMD_CFG, 40'd3);
        sb_push("sat_cs_dac", 32'd2);
        sb_push("sat_cs_adc", 32'd2);
        sb_push("sat_rx", 32'd0);
        sb_push("sat_ow", 32'd1);
        at_neg();
        sb_pop(32'(cs_dac2));
        sb_pop(32'(cs_adc2));
        sb_pop(32'(rx2));
        sb_pop(32'(ow_id2));
        for (int unsigned i = 0; i < 3; i++) begin
            trig2 = ~trig2;
            cyc(1);
        end
        sb_push("sat_small", 32'd3);
        cyc(6);
        sb_pop(32'(count2));
        for (int unsigned i = 0; i < 65531; i++) begin
            trig2 = ~trig2;
            cyc(1);
        end
        sb_push("sat_fffe", 32'hFFFE);
        cyc(6);
        sb_pop(32'(count2));
        trig2 = ~trig2;
        sb_push("sat_ffff", 32'hFFFF);
        cyc(6);
        sb_pop(32'(count2));
        trig2 = ~trig2;
        sb_push("sat_hold", 32'hFFFF);
        sb_push("sat_irq", 32'd1);
        sb_push("sat_estop", 32'd0);
        cyc(6);
        sb_pop(32'(count2));
        sb_pop(32'(irq2));
        sb_pop(32'(estop2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
